// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: address width, reset PC
// and the word-alignment check used by the PC and memory-address registers.
package mips_pkg;

    localparam int unsigned ADDR_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t RESET_PC = 32'h0000_0000;

    // Only the two lowest address bits decide word alignment.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/program_counter_32.sv
// Program counter: an enable flop that loads the next-PC value when hit is high,
// and flags a word-misaligned current address for the exception logic.
module program_counter_32
    import mips_pkg::*;
#(
    parameter int unsigned       WIDTH       = ADDR_W,
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(RESET_PC)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] input1,
    input  logic             hit,
    output logic [WIDTH-1:0] out,
    output logic             misaligned
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    // Next-PC select: take input1 verbatim on write enable, otherwise hold.
    always_comb begin
        pc_d = pc_q;
        if (hit) begin
            pc_d = input1;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_VALUE;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out        = pc_q;
    assign misaligned = ~is_word_aligned(pc_q[1:0]);

endmodule

// File: tb/tb_program_counter_32.sv
// Directed self-checking bench for program_counter_32: reset, enable gating,
// hold, asynchronous reset, misalignment flag and address-range boundaries.
module tb_program_counter_32;

    logic        clock;
    logic        reset;
    logic [31:0] input1;
    logic        hit;
    logic [31:0] out;
    logic        misaligned;

    int checks;
    int failures;

    program_counter_32 dut (
        .clock      (clock),
        .reset      (reset),
        .input1     (input1),
        .hit        (hit),
        .out        (out),
        .misaligned (misaligned)
    );

    // 40 ns clock period, rising edges at 20, 60, 100, ...
    initial begin
        clock = 1'b0;
        forever #20 clock = ~clock;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    task automatic drive_load(input logic [31:0] value);
        @(negedge clock);
        input1 = value;
        hit    = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        input1 = 32'h0000_0040;
        hit    = 1'b1;
        #1;
        checks++;
        if (out !== 32'h0000_0000) begin
            failures++;
            $display("FAIL reset_async_initial: out=%h expected=%h", out, 32'h0000_0000);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if (out !== 32'h0000_0000 || misaligned !== 1'b0) begin
                failures++;
                $display("FAIL reset_held edge %0d: out=%h mis=%b expected=%h mis=0",
                         i, out, misaligned, 32'h0000_0000);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (out !== 32'h0000_0040) begin
            failures++;
            $display("FAIL reset_release_load: out=%h expected=%h", out, 32'h0000_0040);
        end
    endtask

    task automatic test_enable_gating();
        logic [31:0] exp_q [6];
        exp_q[0] = 32'h0000_0004;
        exp_q[1] = 32'h0000_0010;
        exp_q[2] = 32'h0000_0010;
        exp_q[3] = 32'h0000_0024;
        exp_q[4] = 32'h0000_0030;
        exp_q[5] = 32'h0000_0030;
        @(posedge clock);
        #18;
        input1 = 32'h0000_0000;
        hit    = 1'b1;
        fork
            begin
                for (int i = 1; i <= 15; i++) begin
                    #15;
                    input1 = 32'(4 * i);
                end
            end
            begin
                for (int j = 1; j <= 7; j++) begin
                    #30;
                    hit = ~hit;
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    @(posedge clock);
                    #1;
                    checks++;
                    if (out !== exp_q[k] || misaligned !== 1'b0) begin
                        failures++;
                        $display("FAIL enable_gating edge %0d: out=%h mis=%b expected=%h mis=0",
                                 k, out, misaligned, exp_q[k]);
                    end
                end
            end
        join
    endtask

    task automatic test_hold();
        drive_load(32'h0000_0100);
        checks++;
        if (out !== 32'h0000_0100) begin
            failures++;
            $display("FAIL hold_preload: out=%h expected=%h", out, 32'h0000_0100);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            hit    = 1'b0;
            input1 = (i == 5) ? 32'hxxxx_xxxx : $urandom();
            @(posedge clock);
            #1;
            checks++;
            if (out !== 32'h0000_0100) begin
                failures++;
                $display("FAIL hold edge %0d: out=%h expected=%h", i, out, 32'h0000_0100);
            end
        end
    endtask

    task automatic test_async_reset();
        drive_load(32'h0040_0020);
        checks++;
        if (out !== 32'h0040_0020) begin
            failures++;
            $display("FAIL async_preload: out=%h expected=%h", out, 32'h0040_0020);
        end
        @(negedge clock);
        input1 = 32'h0000_0088;
        hit    = 1'b1;
        #5;
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 32'h0000_0000 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_pulse: out=%h mis=%b expected=%h mis=0",
                     out, misaligned, 32'h0000_0000);
        end
        #2;
        reset = 1'b0;
        hit   = 1'b0;
        @(posedge clock);
        #1;
        checks++;
        if (out !== 32'h0000_0000) begin
            failures++;
            $display("FAIL async_reset_after: out=%h expected=%h", out, 32'h0000_0000);
        end
    endtask

    task automatic test_misalign();
        drive_load(32'h0000_0006);
        checks++;
        if (out !== 32'h0000_0006 || misaligned !== 1'b1) begin
            failures++;
            $display("FAIL misalign_6: out=%h mis=%b expected=%h mis=1",
                     out, misaligned, 32'h0000_0006);
        end
        drive_load(32'h0000_0008);
        checks++;
        if (out !== 32'h0000_0008 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL misalign_8: out=%h mis=%b expected=%h mis=0",
                     out, misaligned, 32'h0000_0008);
        end
        drive_load(32'h0000_0003);
        checks++;
        if (misaligned !== 1'b1) begin
            failures++;
            $display("FAIL misalign_3: mis=%b expected=1", misaligned);
        end
        @(negedge clock);
        hit   = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (out !== 32'h0000_0000 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL misalign_reset_clears: out=%h mis=%b expected=%h mis=0",
                     out, misaligned, 32'h0000_0000);
        end
        #2;
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        drive_load(32'hFFFF_FFFC);
        checks++;
        if (out !== 32'hFFFF_FFFC || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL boundary_max: out=%h mis=%b expected=%h mis=0",
                     out, misaligned, 32'hFFFF_FFFC);
        end
        drive_load(32'h0000_0000);
        checks++;
        if (out !== 32'h0000_0000 || misaligned !== 1'b0) begin
            failures++;
            $display("FAIL boundary_wrap: out=%h mis=%b expected=%h mis=0",
                     out, misaligned, 32'h0000_0000);
        end
        drive_load(32'hA5A5_5A5C);
        checks++;
        if (out !== 32'hA5A5_5A5C) begin
            failures++;
            $display("FAIL back_to_back_pattern: out=%h expected=%h", out, 32'hA5A5_5A5C);
        end
        @(negedge clock);
        hit = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_enable_gating();
        test_hold();
        test_async_reset();
        test_misalign();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
